// File: rtl/proc_ctrl_pkg.sv
// ============================================================================
// Module   : proc_ctrl_pkg
// Brief    : Shared run-state type and default limits for the run controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALTED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;

  localparam int unsigned c_DEF_RESET_CYCLES = 5;
  localparam int unsigned c_DEF_MAX_CYCLES   = 1000;
  localparam int unsigned c_DEF_LOOP_LIMIT   = 2;

  // Bits needed to hold the values 0..v, never less than one.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_q <= '0;
    end else if (i_en && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/proc_run_controller.sv
// ============================================================================
// Module   : proc_run_controller
// Brief    : Sequences core reset, gates core execution and detects program end.
// Revision : 1.0
// ============================================================================
`default_nettype none

module proc_run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_CYCLES = c_DEF_RESET_CYCLES,
  parameter int unsigned MAX_CYCLES   = c_DEF_MAX_CYCLES,
  parameter int unsigned LOOP_LIMIT   = c_DEF_LOOP_LIMIT
) (
  input  logic             t_clk,
  input  logic             t_rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [PC_W-1:0]  core_pc,
  input  logic             core_retire,
  output logic             core_rst,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned c_RC_W = cnt_width(RESET_CYCLES);
  localparam int unsigned c_LP_W = cnt_width(LOOP_LIMIT);
  localparam logic [63:0] c_WDOG = 64'(MAX_CYCLES);

  run_state_t        r_state;
  logic [PC_W-1:0]   r_last_pc;
  logic              r_pc_valid;

  logic [c_RC_W-1:0] w_rst_cnt;
  logic [c_LP_W-1:0] w_loop_cnt;
  logic              w_start_run;
  logic              w_active;
  logic              w_pc_same;
  logic              w_loop_clr;
  logic              w_loop_hit;
  logic              w_wdog_hit;
  logic              w_rst_done;

  assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_HALTED) ||
                                 (r_state == ST_TIMEOUT));
  assign w_active    = (r_state == ST_RUN) && core_en;
  assign w_pc_same   = r_pc_valid && (core_pc == r_last_pc);
  assign w_loop_clr  = w_start_run || (w_active && !w_pc_same);
  assign w_loop_hit  = w_active && w_pc_same && (w_loop_cnt == c_LP_W'(LOOP_LIMIT - 1));
  // The watchdog fires on the edge that moves cycle_count onto MAX_CYCLES;
  // a saturated counter never moves again, so it cannot fire there.
  assign w_wdog_hit  = w_active && (MAX_CYCLES != 0) && (cycle_count != '1) &&
                       ((64'(cycle_count) + 64'd1) == c_WDOG);
  assign w_rst_done  = (r_state == ST_RESET) && (w_rst_cnt == c_RC_W'(RESET_CYCLES - 1));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (t_clk),
    .rst   (t_rst),
    .i_clr (w_start_run),
    .i_en  (w_active),
    .o_q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (t_clk),
    .rst   (t_rst),
    .i_clr (w_start_run),
    .i_en  (w_active && core_retire),
    .o_q   (retire_count)
  );

  sat_counter #(.W(c_RC_W)) u_rst_cnt (
    .clk   (t_clk),
    .rst   (t_rst),
    .i_clr (w_start_run),
    .i_en  (r_state == ST_RESET),
    .o_q   (w_rst_cnt)
  );

  sat_counter #(.W(c_LP_W)) u_loop_cnt (
    .clk   (t_clk),
    .rst   (t_rst),
    .i_clr (w_loop_clr),
    .i_en  (w_active && w_pc_same),
    .o_q   (w_loop_cnt)
  );

  // Capture the PC of the first enabled cycle and of every PC change.
  always_ff @(posedge t_clk) begin
    if (t_rst || w_start_run) begin
      r_pc_valid <= 1'b0;
      r_last_pc  <= '0;
    end else if (w_active && !w_pc_same) begin
      r_pc_valid <= 1'b1;
      r_last_pc  <= core_pc;
    end
  end

  always_ff @(posedge t_clk) begin
    if (t_rst) begin
      r_state  <= ST_IDLE;
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
          core_en <= 1'b0;
          if (start) begin
            r_state  <= ST_RESET;
            core_rst <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        ST_RESET: begin
          core_en <= 1'b0;
          if (w_rst_done) begin
            r_state  <= ST_RUN;
            core_rst <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_loop_hit) begin
            r_state <= ST_HALTED;
            done    <= 1'b1;
            core_en <= 1'b0;
            busy    <= 1'b0;
          end else if (w_wdog_hit) begin
            r_state <= ST_TIMEOUT;
            timeout <= 1'b1;
            core_en <= 1'b0;
            busy    <= 1'b0;
          end else begin
            // A step seen while the granted enable is still up is dropped.
            core_en <= step_mode ? (step && !core_en) : 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          core_rst <= 1'b1;
          core_en  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_proc_run_controller.sv
// ============================================================================
// Module   : tb_proc_run_controller
// Brief    : Directed and random checks of two controller configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_proc_run_controller;

  localparam int PH_IDLE = 0, PH_RST = 1, PH_RUN = 2, PH_HALT = 3, PH_TMO = 4;

  typedef struct {
    int          ph;
    int          rem;
    bit          en;
    longint      cyc;
    longint      ret;
    bit          pcv;
    logic [63:0] lpc;
    int          loops;
    bit          dn;
    bit          to;
  } mdl_t;

  logic        t_clk = 1'b0;
  logic        t_rst, start, step_mode, step, core_retire;
  logic [63:0] core_pc;

  logic        a_core_rst, a_core_en, a_busy, a_done, a_tmo;
  logic [31:0] a_cyc, a_ret;
  logic        b_core_rst, b_core_en, b_busy, b_done, b_tmo;
  logic [2:0]  b_cyc, b_ret;

  mdl_t        ma, mb;
  int          n_vec = 0, n_bad = 0;
  int          en_cnt = 0, ret_sent = 0, pc_mode = 0, n;
  bit          rt_rand = 1'b1;
  logic [63:0] prog[$];

  always #5 t_clk = ~t_clk;

  proc_run_controller #(
    .PC_W(64), .CNT_W(32), .RESET_CYCLES(5), .MAX_CYCLES(20), .LOOP_LIMIT(2)
  ) u_dut_a (
    .t_clk(t_clk), .t_rst(t_rst), .start(start), .step_mode(step_mode), .step(step),
    .core_pc(core_pc), .core_retire(core_retire), .core_rst(a_core_rst),
    .core_en(a_core_en), .cycle_count(a_cyc), .retire_count(a_ret), .busy(a_busy),
    .done(a_done), .timeout(a_tmo)
  );

  proc_run_controller #(
    .PC_W(64), .CNT_W(3), .RESET_CYCLES(3), .MAX_CYCLES(0), .LOOP_LIMIT(3)
  ) u_dut_b (
    .t_clk(t_clk), .t_rst(t_rst), .start(start), .step_mode(step_mode), .step(step),
    .core_pc(core_pc), .core_retire(core_retire), .core_rst(b_core_rst),
    .core_en(b_core_en), .cycle_count(b_cyc), .retire_count(b_ret), .busy(b_busy),
    .done(b_done), .timeout(b_tmo)
  );

  function automatic mdl_t m_idle();
    mdl_t m;
    m.ph = PH_IDLE; m.rem = 0; m.en = 0; m.cyc = 0; m.ret = 0;
    m.pcv = 0; m.lpc = '0; m.loops = 0; m.dn = 0; m.to = 0;
    return m;
  endfunction

  // One clock of the run controller as seen from outside.
  function automatic mdl_t mstep(mdl_t m, bit rst, bit st, bit sm, bit sp, logic [63:0] pc,
                                 bit rt, int rc, int mx, int ll, longint cmax);
    mdl_t x = m;
    if (rst) return m_idle();
    case (m.ph)
      PH_IDLE, PH_HALT, PH_TMO: begin
        if (st) begin
          x = m_idle();
          x.ph  = PH_RST;
          x.rem = rc;
        end
      end
      PH_RST: begin
        if (m.rem == 1) x.ph = PH_RUN;
        else x.rem = m.rem - 1;
      end
      PH_RUN: begin
        if (m.en) begin
          x.cyc = (m.cyc >= cmax) ? cmax : m.cyc + 1;
          if (rt) x.ret = (m.ret >= cmax) ? cmax : m.ret + 1;
          if (m.pcv && pc == m.lpc) x.loops = m.loops + 1;
          else begin x.loops = 0; x.lpc = pc; x.pcv = 1; end
        end
        if (m.en && x.loops >= ll) begin
          x.ph = PH_HALT; x.dn = 1; x.en = 0;
        end else if (m.en && mx != 0 && x.cyc == mx) begin
          x.ph = PH_TMO; x.to = 1; x.en = 0;
        end else begin
          x.en = sm ? (sp && !m.en) : 1'b1;
        end
      end
      default: x = m_idle();
    endcase
    return x;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check_eq("A.core_rst", 64'(a_core_rst), 64'(ma.ph == PH_IDLE || ma.ph == PH_RST));
    check_eq("A.core_en", 64'(a_core_en), 64'(ma.en));
    check_eq("A.busy", 64'(a_busy), 64'(ma.ph == PH_RST || ma.ph == PH_RUN));
    check_eq("A.done", 64'(a_done), 64'(ma.dn));
    check_eq("A.timeout", 64'(a_tmo), 64'(ma.to));
    check_eq("A.cycle_count", 64'(a_cyc), ma.cyc);
    check_eq("A.retire_count", 64'(a_ret), ma.ret);
    check_eq("B.core_rst", 64'(b_core_rst), 64'(mb.ph == PH_IDLE || mb.ph == PH_RST));
    check_eq("B.core_en", 64'(b_core_en), 64'(mb.en));
    check_eq("B.busy", 64'(b_busy), 64'(mb.ph == PH_RST || mb.ph == PH_RUN));
    check_eq("B.done", 64'(b_done), 64'(mb.dn));
    check_eq("B.timeout", 64'(b_tmo), 64'(mb.to));
    check_eq("B.cycle_count", 64'(b_cyc), mb.cyc);
    check_eq("B.retire_count", 64'(b_ret), mb.ret);
  endtask

  // Advance one clock, update the models, compare, then feed the next PC
  // the way a core would: a new PC after each enabled cycle.
  task automatic tick();
    bit ena_pre;
    ena_pre = (a_core_en === 1'b1);
    @(posedge t_clk);
    ma = mstep(ma, t_rst, start, step_mode, step, core_pc, core_retire, 5, 20, 2, 64'hFFFF_FFFF);
    mb = mstep(mb, t_rst, start, step_mode, step, core_pc, core_retire, 3, 0, 3, 7);
    if (ena_pre) begin
      en_cnt++;
      if (core_retire) ret_sent++;
    end
    #1;
    cmp_all();
    if (a_core_en === 1'b1) begin
      if (pc_mode == 1 && prog.size() > 0) core_pc = prog.pop_front();
      else if (pc_mode == 2) core_pc = core_pc + 64'd4;
    end
    if (pc_mode == 3) core_pc = 64'($urandom_range(0, 3)) << 2;
    if (rt_rand) core_retire = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rst_release(input string tag);
    n = 0;
    while (a_core_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, ".rst_len"}, 64'(n), 64'd5);
    check_eq({tag, ".en_first"}, 64'(a_core_en), 64'd0);
  endtask

  initial begin
    ma = m_idle(); mb = m_idle();
    t_rst = 1; start = 0; step_mode = 0; step = 0; core_retire = 0; core_pc = '0;
    tick(); tick();
    check_eq("reset.core_rst", 64'(a_core_rst), 64'd1);
    check_eq("reset.cycle", 64'(a_cyc), 64'd0);
    check_eq("reset.busy", 64'(a_busy), 64'd0);
    t_rst = 0;
    tick(); tick();

    // Start at cycle 3, then a program that ends in a branch-to-self.
    prog = '{64'h0, 64'h4, 64'h8, 64'h8, 64'h8};
    pc_mode = 1;
    start = 1; tick(); start = 0;
    check_eq("start.busy", 64'(a_busy), 64'd1);
    wait_rst_release("start");
    tick();
    check_eq("start.en_rise", 64'(a_core_en), 64'd1);
    en_cnt = 0; ret_sent = 0;
    for (int i = 0; i < 30 && a_done !== 1'b1; i++) tick();
    check_eq("loop.done", 64'(a_done), 64'd1);
    check_eq("loop.cycle", 64'(a_cyc), 64'd5);
    check_eq("loop.retire", 64'(a_ret), 64'(ret_sent));
    check_eq("loop.core_en", 64'(a_core_en), 64'd0);
    check_eq("loop.en_cnt", 64'(en_cnt), 64'd5);

    // Restart from HALTED with one retire per enabled cycle.
    rt_rand = 0; core_retire = 1; core_pc = 64'h40;
    prog = '{64'h0, 64'h4, 64'h8, 64'h8, 64'h8};
    start = 1; tick(); start = 0;
    check_eq("restart.done_clr", 64'(a_done), 64'd0);
    check_eq("restart.cycle_clr", 64'(a_cyc), 64'd0);
    check_eq("restart.retire_clr", 64'(a_ret), 64'd0);
    for (int i = 0; i < 40 && a_done !== 1'b1; i++) tick();
    check_eq("restart.done", 64'(a_done), 64'd1);
    check_eq("restart.cycle", 64'(a_cyc), 64'd5);
    check_eq("restart.retire", 64'(a_ret), 64'd5);

    // Single step from HALTED, with the PC always moving.
    rt_rand = 1; pc_mode = 2; core_pc = 64'h100; step_mode = 1;
    start = 1; tick(); start = 0;
    wait_rst_release("step");
    tick(); tick();
    check_eq("step.idle_en", 64'(a_core_en), 64'd0);
    en_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1; tick(); step = 0;
      tick(); tick(); tick();
    end
    check_eq("step.en_cnt", 64'(en_cnt), 64'd3);
    check_eq("step.cycle", 64'(a_cyc), 64'd3);
    step = 1; tick(); tick(); step = 0;
    tick(); tick();
    check_eq("step.b2b_en_cnt", 64'(en_cnt), 64'd4);
    check_eq("step.b2b_cycle", 64'(a_cyc), 64'd4);

    // Switch to free-run mid-RUN, then reset at cycle 10 of the run.
    step_mode = 0;
    repeat (10) tick();
    t_rst = 1; tick(); t_rst = 0;
    check_eq("midrst.core_rst", 64'(a_core_rst), 64'd1);
    check_eq("midrst.cycle", 64'(a_cyc), 64'd0);
    check_eq("midrst.retire", 64'(a_ret), 64'd0);
    check_eq("midrst.busy", 64'(a_busy), 64'd0);

    // Watchdog.
    core_pc = 64'h200;
    start = 1; tick(); start = 0;
    wait_rst_release("wdog");
    for (int i = 0; i < 60 && a_tmo !== 1'b1; i++) tick();
    check_eq("wdog.timeout", 64'(a_tmo), 64'd1);
    check_eq("wdog.cycle", 64'(a_cyc), 64'd20);
    check_eq("wdog.done", 64'(a_done), 64'd0);
    tick(); tick();
    check_eq("wdog.core_en", 64'(a_core_en), 64'd0);
    check_eq("wdog.cycle_hold", 64'(a_cyc), 64'd20);

    // Random traffic against the models.
    pc_mode = 3;
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      step  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) step_mode = ~step_mode;
      t_rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    t_rst = 0; start = 0; step = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
